seq_divider_16by8: RTL and testbench
====================================

Name: seq_divider_16by8

Overview:
- Iterative radix-2 restoring unsigned divider. It is the inverse datapath to the pipelined 8-bit multiplier: it recovers operands from 16-bit products.
- Sits on a valid/ready stream and produces one quotient bit per cycle.
- Used as a standalone checker and as a building block wherever a product must be divided back down.

Parameters:
- DW, 16, dividend and quotient width (bits).
- SW, 8, divisor and remainder width (bits). Must satisfy SW <= DW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset. One clock domain; reset is asynchronous and active-high.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  divider can accept an operand pair.
- dividend  input  DW  unsigned dividend.
- divisor  input  SW  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  DW  unsigned quotient.
- remainder  output  SW  unsigned remainder.
- div_by_zero  output  1  the result came from a zero divisor.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on the edge where in_valid&&in_ready. Latch dividend, divisor and an (SW+1)-bit partial remainder=0, then clear the counter.
  - If divisor!=0, go to BUSY. If divisor==0, go to DONE and load quotient={DW{1'b1}}, remainder=dividend[SW-1:0], div_by_zero=1.
- BUSY:
  - in_ready=0.
  - Each edge: shift {partial, dividend_reg} left by 1. Trial-subtract divisor from the upper SW+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - The counter increments each edge. After exactly DW iterations, go to DONE with quotient/remainder registered and div_by_zero=0.
- DONE:
  - out_valid=1 and in_ready=0.
  - quotient/remainder/div_by_zero stay stable while out_valid&&!out_ready (hold under backpressure, indefinitely).
  - On the edge with out_ready=1, go to IDLE and deassert out_valid. Outputs keep their last values (not cleared).
  - No accept in the same cycle as the result handoff. in_ready rises the cycle after handoff, so the minimum initiation interval is DW+2 cycles.
- Latency, measured from the accept edge E:
  - Normal: out_valid is visible after edge E+DW+1 (1 load edge + DW iteration edges).
  - Divide-by-zero: out_valid is visible after edge E+1.
- Arithmetic:
  - Fully unsigned. Invariant: dividend == quotient*divisor + remainder, with remainder < divisor.
  - Partial remainder is SW+1 bits internally so the trial subtract never overflows. The remainder output is its low SW bits, and the top bit is always 0 at completion.
- Boundaries:
  - in_valid held while busy is ignored, and the operands are not sampled until in_ready=1.
  - Changing dividend/divisor inputs mid-operation has no effect because the operands are latched.
  - rst asserted in any state immediately returns all outputs to reset values. Any in-flight result is discarded and no out_valid is produced for it.
  - divisor > dividend gives quotient=0, remainder=dividend.
  - dividend=0 gives quotient=0, remainder=0 and still takes the full latency.

Test Plan:
- Reset then 1024/32 -> out_valid exactly 17 cycles after the accept edge; quotient=32, remainder=0, div_by_zero=0.
- Back-to-back stream 888/74, 288/24, 305/7 with out_ready=1 -> 12 r0, 12 r0, 43 r4 in order. in_ready low during BUSY/DONE; accepts spaced 18 cycles.
- Extremes: 65535/1 -> 65535 r0; 65535/255 -> 257 r0; 5/200 -> 0 r5; 0/9 -> 0 r0.
- 500/0 -> out_valid after edge E+1; quotient=16'hFFFF, remainder=8'hF4, div_by_zero=1. The following 500/4 -> 125 r0, div_by_zero=0.
- Backpressure: out_ready=0 for 10 cycles after 1000/33 completes -> out_valid and outputs (30 r10) stable throughout; in_ready=0. Handoff on the first out_ready=1 edge; in_ready=1 the next cycle.
- Assert rst for 1 cycle at iteration 7 of 4000/13 -> out_valid=0, in_ready=1, outputs zero immediately. No stale result appears. A new 4000/13 -> 307 r9.

Source files
------------

// File: rtl/seq_divider_16by8.sv
// Iterative radix-2 restoring unsigned divider: DW-bit dividend by SW-bit divisor,
// one quotient bit per cycle, valid/ready on both the operand and result sides.
module seq_divider_16by8 #(
  parameter int unsigned DW = 16,
  parameter int unsigned SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [SW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;    // dividend bits shift out the top, quotient bits shift in
  logic [SW-1:0] dvs_q, dvs_d;
  logic [SW:0]   part_q, part_d;  // one extra bit so the trial subtract never overflows
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [SW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [SW+1:0] shifted;
  logic [SW+1:0] trial;
  logic          q_bit;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted = {part_q, dvd_q[DW-1]};
    trial   = shifted - {2'b00, dvs_q};
    q_bit   = ~trial[SW+1];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          part_d = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            state_d = StDone;
            quo_d   = '1;
            rem_d   = dividend[SW-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        part_d = q_bit ? trial[SW:0] : shifted[SW:0];
        dvd_d  = {dvd_q[DW-2:0], q_bit};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = StDone;
          quo_d   = {dvd_q[DW-2:0], q_bit};
          rem_d   = part_d[SW-1:0];
          dbz_d   = 1'b0;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags decode straight from the state; results come from registers.
  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StDone);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Bench for seq_divider_16by8: vector table streamed through a scoreboard,
// plus backpressure and mid-operation reset sequences.
module tb_seq_divider_16by8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  seq_divider_16by8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[26];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   lat_seen = 0;

  // Cycle counter; read by the bench 2 time units after each rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: checks handoffs against the scoreboard and watches invariants.
  logic        ov_prev = 1'b0;
  logic        or_prev = 1'b0;
  logic [15:0] q_prev = '0;
  logic [7:0]  r_prev = '0;
  logic        z_prev = 1'b0;
  exp_t        e_mon;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) lat_seen = cyc - acc_cyc;
      if (out_valid && in_ready) begin
        n_err++;
        $display("FAIL in_ready_during_done: in_ready=%0b required 0", in_ready);
      end
      if (out_valid && ov_prev && !or_prev &&
          (quotient !== q_prev || remainder !== r_prev || div_by_zero !== z_prev)) begin
        n_err++;
        $display("FAIL hold: got %0d r%0d z%0b, held value was %0d r%0d z%0b",
                 quotient, remainder, div_by_zero, q_prev, r_prev, z_prev);
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL stale_result: got %0d r%0d with no result outstanding",
                   quotient, remainder);
        end else begin
          e_mon = sb.pop_front();
          if (quotient !== e_mon.q || remainder !== e_mon.r || div_by_zero !== e_mon.z ||
              lat_seen != e_mon.lat) begin
            n_err++;
            $display("FAIL result: got %0d r%0d z%0b lat %0d, required %0d r%0d z%0b lat %0d",
                     quotient, remainder, div_by_zero, lat_seen,
                     e_mon.q, e_mon.r, e_mon.z, e_mon.lat);
          end
        end
      end
    end
    ov_prev = out_valid;
    or_prev = out_ready;
    q_prev  = quotient;
    r_prev  = remainder;
    z_prev  = div_by_zero;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present an operand pair, wait for acceptance, then scramble the inputs.
  task automatic send(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                      input logic [7:0] r, input logic z, output int acc);
    int   t;
    exp_t e;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    acc = cyc;
    if (!in_ready) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      e.q   = q;
      e.r   = r;
      e.z   = z;
      e.lat = (b == 8'd0) ? 1 : 17;
      sb.push_back(e);
      acc_cyc = cyc;
    end
    step();
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 400) begin
      step();
      t++;
    end
    if (sb.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic check_reset(input string name);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 ||
        remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL %s: in_ready=%0b out_valid=%0b q=%0d r=%0d z=%0b, required 1 0 0 0 0",
               name, in_ready, out_valid, quotient, remainder, div_by_zero);
    end
  endtask

  initial begin
    int acc;
    int prev_acc;
    int prev_lat;
    int t;
    logic [15:0] ra;
    logic [7:0]  rb;

    tbl[0] = '{16'd1024,  8'd32,  16'd32,    8'd0,   1'b0};
    tbl[1] = '{16'd888,   8'd74,  16'd12,    8'd0,   1'b0};
    tbl[2] = '{16'd288,   8'd24,  16'd12,    8'd0,   1'b0};
    tbl[3] = '{16'd305,   8'd7,   16'd43,    8'd4,   1'b0};
    tbl[4] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
    tbl[5] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
    tbl[6] = '{16'd5,     8'd200, 16'd0,     8'd5,   1'b0};
    tbl[7] = '{16'd0,     8'd9,   16'd0,     8'd0,   1'b0};
    tbl[8] = '{16'd500,   8'd0,   16'hFFFF,  8'hF4,  1'b1};
    tbl[9] = '{16'd500,   8'd4,   16'd125,   8'd0,   1'b0};
    for (int i = 10; i < 26; i++) begin
      ra = 16'($urandom);
      rb = (i == 20) ? 8'd0 : 8'($urandom);
      if (rb == 8'd0) tbl[i] = '{ra, rb, 16'hFFFF, ra[7:0], 1'b1};
      else            tbl[i] = '{ra, rb, ra / {8'd0, rb}, 8'(ra % {8'd0, rb}), 1'b0};
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) step();
    check_reset("reset_state");
    rst = 1'b0;
    step();

    // Streamed table; accepts must be spaced by result latency + 1.
    prev_acc = 0;
    prev_lat = 0;
    for (int i = 0; i < 26; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, acc);
      if (i > 0) begin
        n_vec++;
        if (acc - prev_acc != prev_lat + 1) begin
          n_err++;
          $display("FAIL accept_spacing[%0d]: got %0d, required %0d",
                   i, acc - prev_acc, prev_lat + 1);
        end
      end
      prev_acc = acc;
      prev_lat = (tbl[i].b == 8'd0) ? 1 : 17;
    end
    drain();

    // Backpressure: result must hold for 10 cycles, then hand off on the first ready.
    out_ready = 1'b0;
    send(16'd1000, 8'd33, 16'd30, 8'd10, 1'b0, acc);
    t = 0;
    while (!out_valid && t < 40) begin
      step();
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd30 ||
          remainder !== 8'd10 || div_by_zero !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure[%0d]: v=%0b rdy=%0b q=%0d r=%0d z=%0b, required 1 0 30 10 0",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'd30) begin
      n_err++;
      $display("FAIL after_handoff: v=%0b rdy=%0b q=%0d, required 0 1 30",
               out_valid, in_ready, quotient);
    end
    drain();

    // Reset during iteration 7 discards the in-flight result.
    send(16'd4000, 8'd13, 16'd307, 8'd9, 1'b0, acc);
    repeat (6) step();
    rst = 1'b1;
    #1;
    check_reset("reset_mid_op");
    sb.delete();
    step();
    rst = 1'b0;
    repeat (30) step();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL no_stale: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
    send(16'd4000, 8'd13, 16'd307, 8'd9, 1'b0, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
